// File: rtl/bridge_pkg.sv
// Shared types and burst constants for the dcache-to-AXI line bridge.
// Both engines issue fixed 4-beat INCR bursts of 32-bit words.
package bridge_pkg;

  typedef enum logic [1:0] {
    R_IDLE,
    R_AR,
    R_DATA,
    R_DONE
  } r_state_e;

  typedef enum logic [2:0] {
    W_IDLE,
    W_AW,
    W_DATA,
    W_RESP,
    W_DONE
  } w_state_e;

  localparam logic [7:0] BURST_LEN  = 8'd3;
  localparam logic [2:0] BURST_SIZE = 3'b010;
  localparam logic [1:0] BURST_INCR = 2'b01;

  function automatic logic [31:0] line_addr(
    input logic [31:0] a
  );
    return {a[31:4], 4'h0};
  endfunction

endpackage

// File: rtl/dcache_axi_bridge.sv
// Line-granular dcache read/write responder driving AXI4 4-beat bursts.
// A read is held off while any write is in flight or being accepted.
module dcache_axi_bridge
  import bridge_pkg::*;
#(
  parameter logic [3:0] AXI_ID = 4'd1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         cpu_ren,
  input  logic [31:0]  cpu_raddr,
  output logic         dev_rrdy,
  output logic         ren_received,
  output logic         dev_rvalid,
  output logic [127:0] dev_rdata,
  input  logic [3:0]   cpu_wen,
  input  logic [31:0]  cpu_waddr,
  input  logic [127:0] cpu_wdata,
  output logic         dev_wrdy,
  output logic         write_finish,
  output logic [3:0]   arid,
  output logic [31:0]  araddr,
  output logic [7:0]   arlen,
  output logic [2:0]   arsize,
  output logic [1:0]   arburst,
  output logic         arvalid,
  input  logic         arready,
  input  logic [3:0]   rid,
  input  logic [31:0]  rdata,
  input  logic [1:0]   rresp,
  input  logic         rlast,
  input  logic         rvalid,
  output logic         rready,
  output logic [3:0]   awid,
  output logic [31:0]  awaddr,
  output logic [7:0]   awlen,
  output logic [2:0]   awsize,
  output logic [1:0]   awburst,
  output logic         awvalid,
  input  logic         awready,
  output logic [3:0]   wid,
  output logic [31:0]  wdata,
  output logic [3:0]   wstrb,
  output logic         wlast,
  output logic         wvalid,
  input  logic         wready,
  input  logic [3:0]   bid,
  input  logic [1:0]   bresp,
  input  logic         bvalid,
  output logic         bready
);

  r_state_e         r_state, r_next;
  w_state_e         w_state, w_next;
  logic [31:0]      raddr_q, waddr_q;
  logic [1:0]       rbeat, wbeat;
  logic [3:0][31:0] rline, wline;
  logic             r_accept, w_accept;

  // Responses carry no information this bridge acts on.
  logic unused_ok;
  assign unused_ok = ^{rid, rresp, bid, bresp,
                       cpu_raddr[3:0], cpu_waddr[3:0]};

  assign arid    = AXI_ID;
  assign awid    = AXI_ID;
  assign wid     = AXI_ID;
  assign arlen   = BURST_LEN;
  assign awlen   = BURST_LEN;
  assign arsize  = BURST_SIZE;
  assign awsize  = BURST_SIZE;
  assign arburst = BURST_INCR;
  assign awburst = BURST_INCR;

  assign araddr    = raddr_q;
  assign awaddr    = waddr_q;
  assign dev_rdata = rline;
  assign wdata     = wline[wbeat];

  // Write wins a same-cycle tie so writebacks precede refills.
  assign w_accept = (w_state == W_IDLE) && (cpu_wen != 4'h0);
  assign r_accept = (r_state == R_IDLE) && cpu_ren &&
                    (w_state == W_IDLE) && (cpu_wen == 4'h0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= R_IDLE;
      raddr_q <= '0;
      rbeat   <= '0;
      rline   <= '0;
    end else begin
      r_state <= r_next;
      if (r_accept) begin
        raddr_q <= line_addr(cpu_raddr);
        rbeat   <= '0;
      end
      if (r_state == R_DATA && rvalid) begin
        rline[rbeat] <= rdata;
        rbeat        <= rbeat + 2'd1;
      end
    end
  end

  always_comb begin
    r_next       = r_state;
    dev_rrdy     = 1'b0;
    ren_received = 1'b0;
    arvalid      = 1'b0;
    rready       = 1'b0;
    dev_rvalid   = 1'b0;
    unique case (r_state)
      R_IDLE: begin
        dev_rrdy     = 1'b1;
        ren_received = r_accept;
        if (r_accept) r_next = R_AR;
      end
      R_AR: begin
        arvalid = 1'b1;
        if (arready) r_next = R_DATA;
      end
      R_DATA: begin
        rready = 1'b1;
        if (rvalid && rlast) r_next = R_DONE;
      end
      R_DONE: begin
        dev_rvalid = 1'b1;
        r_next     = R_IDLE;
      end
      default: r_next = R_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      w_state <= W_IDLE;
      waddr_q <= '0;
      wbeat   <= '0;
      wline   <= '0;
    end else begin
      w_state <= w_next;
      if (w_accept) begin
        waddr_q <= line_addr(cpu_waddr);
        wline   <= cpu_wdata;
        wbeat   <= '0;
      end
      if (w_state == W_DATA && wready) begin
        wbeat <= wbeat + 2'd1;
      end
    end
  end

  always_comb begin
    w_next       = w_state;
    dev_wrdy     = 1'b0;
    awvalid      = 1'b0;
    wvalid       = 1'b0;
    wstrb        = 4'h0;
    wlast        = 1'b0;
    bready       = 1'b0;
    write_finish = 1'b0;
    unique case (w_state)
      W_IDLE: begin
        dev_wrdy = 1'b1;
        if (w_accept) w_next = W_AW;
      end
      W_AW: begin
        awvalid = 1'b1;
        if (awready) w_next = W_DATA;
      end
      W_DATA: begin
        wvalid = 1'b1;
        wstrb  = 4'hF;
        wlast  = (wbeat == 2'd3);
        if (wready && wbeat == 2'd3) w_next = W_RESP;
      end
      W_RESP: begin
        bready = 1'b1;
        if (bvalid) w_next = W_DONE;
      end
      W_DONE: begin
        write_finish = 1'b1;
        w_next       = W_IDLE;
      end
      default: w_next = W_IDLE;
    endcase
  end

endmodule
